im_port_arbiter: RTL and testbench

- Arbitrates the single-port 4 KB instruction memory between two requesters: the IF stage (read-only fetch) and the program loader/debug port (read or write).
- Fetch normally has priority. A starvation counter guarantees the loader eventually gets access.
- A hold mode gives the loader exclusive access for program download and stalls fetch.
- Sits between the IF stage / loader and the IM array. Grant is combinational; read data returns registered one cycle later.

---
 rtl/im_port_arbiter.sv | 113 +++++++++++
 tb/tb_im_port_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/im_port_arbiter.sv
// Arbiter for the single-port instruction memory: IF fetch vs. program loader/debug port.
// Fetch has priority, a starvation counter bounds loader wait, and hold mode gives the loader exclusive access.
module im_port_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic              if_misalign,
    output logic              stall_if,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [31:0]       ld_addr,
    input  logic [31:0]       ld_wdata,
    input  logic              ld_hold,
    output logic              ld_gnt,
    output logic              ld_valid,
    output logic [31:0]       ld_rdata,
    output logic              ld_mode,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic {RUN, LOAD} state_t;

    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    state_t            state_reg, state_next;
    logic [3:0]        wait_cnt_reg, wait_cnt_next;
    logic              if_gnt_raw, ld_gnt_raw;
    logic              if_valid_reg, ld_valid_reg, if_misalign_reg, ld_mode_reg;
    logic [31:0]       if_instr_reg, ld_rdata_reg;
    logic [ADDR_W-1:0] if_word, ld_word;
    logic              unused_addr_bits;

    assign if_word = if_addr[ADDR_W+1:2];
    assign ld_word = ld_addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], ld_addr[31:ADDR_W+2], ld_addr[1:0]};

    always_comb begin
        state_next    = state_reg;
        if_gnt_raw    = 1'b0;
        ld_gnt_raw    = 1'b0;
        wait_cnt_next = 4'd0;
        case (state_reg)
            RUN: begin
                if (ld_hold)
                    state_next = LOAD;
                if (ld_req && (!if_req || wait_cnt_reg == MAX_W))
                    ld_gnt_raw = 1'b1;
                else if (if_req)
                    if_gnt_raw = 1'b1;
            end
            LOAD: begin
                if (!ld_hold)
                    state_next = RUN;
                ld_gnt_raw = ld_req;
            end
            default: state_next = RUN;
        endcase
        // Count only denied loader cycles in RUN; entering or staying in LOAD keeps it clear.
        if (state_next == RUN && ld_req && !ld_gnt_raw)
            wait_cnt_next = (wait_cnt_reg == MAX_W) ? MAX_W : wait_cnt_reg + 4'd1;
    end

    // Combinational outputs are forced low while reset is asserted.
    assign if_gnt    = rst_n & if_gnt_raw;
    assign ld_gnt    = rst_n & ld_gnt_raw;
    assign stall_if  = rst_n & if_req & ~if_gnt_raw;
    assign mem_we    = ld_gnt & ld_we;
    assign mem_wdata = ld_gnt ? ld_wdata : 32'd0;
    assign mem_addr  = if_gnt ? if_word : (ld_gnt ? ld_word : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= RUN;
            wait_cnt_reg    <= 4'd0;
            ld_mode_reg     <= 1'b0;
            if_valid_reg    <= 1'b0;
            if_instr_reg    <= 32'd0;
            if_misalign_reg <= 1'b0;
            ld_valid_reg    <= 1'b0;
            ld_rdata_reg    <= 32'd0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            ld_mode_reg  <= (state_next == LOAD);
            if_valid_reg <= if_gnt;
            ld_valid_reg <= ld_gnt & ~ld_we;
            if (if_gnt) begin
                if_instr_reg    <= mem_rdata;
                if_misalign_reg <= (if_addr[1:0] != 2'b00);
            end
            if (ld_gnt && !ld_we)
                ld_rdata_reg <= mem_rdata;
        end
    end

    assign if_valid    = if_valid_reg;
    assign if_instr    = if_instr_reg;
    assign if_misalign = if_misalign_reg;
    assign ld_valid    = ld_valid_reg;
    assign ld_rdata    = ld_rdata_reg;
    assign ld_mode     = ld_mode_reg;

endmodule

// File: tb/tb_im_port_arbiter.sv
// Table-driven bench for im_port_arbiter with a response scoreboard and a behavioural IM array.
module tb_im_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0, ld_req = 1'b0, ld_we = 1'b0, ld_hold = 1'b0;
    logic [31:0] if_addr = '0, ld_addr = '0, ld_wdata = '0;
    logic        if_gnt, if_valid, if_misalign, stall_if;
    logic        ld_gnt, ld_valid, ld_mode, mem_we;
    logic [31:0] if_instr, ld_rdata, mem_wdata, mem_rdata;
    logic [9:0]  mem_addr;

    int checks = 0;
    int errors = 0;

    logic [31:0] im [1024];

    always #5 clk = ~clk;

    assign mem_rdata = im[mem_addr];
    always @(posedge clk) if (mem_we) im[mem_addr] <= mem_wdata;

    im_port_arbiter #(.ADDR_W(10), .MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid),
        .if_instr(if_instr), .if_misalign(if_misalign), .stall_if(stall_if),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_hold(ld_hold), .ld_gnt(ld_gnt), .ld_valid(ld_valid), .ld_rdata(ld_rdata),
        .ld_mode(ld_mode), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        ld_req;
        logic        ld_we;
        logic [31:0] ld_addr;
        logic [31:0] ld_wdata;
        logic        ld_hold;
        logic        e_if_gnt;
        logic        e_ld_gnt;
        logic        e_mode;
        logic [31:0] e_data;
        logic        e_mis;
        logic [9:0]  e_maddr;
    } vec_t;

    typedef struct {
        logic        is_ld;
        logic [31:0] data;
        logic        mis;
    } resp_t;

    vec_t  vecs[$];
    resp_t sb[$];

    function automatic vec_t mk(logic ir, logic [31:0] ia, logic lr, logic lw, logic [31:0] la,
                                logic [31:0] ld, logic lh, logic eig, logic elg, logic em,
                                logic [31:0] ed, logic emis, logic [9:0] ema);
        vec_t v;
        v.if_req = ir; v.if_addr = ia; v.ld_req = lr; v.ld_we = lw; v.ld_addr = la;
        v.ld_wdata = ld; v.ld_hold = lh; v.e_if_gnt = eig; v.e_ld_gnt = elg; v.e_mode = em;
        v.e_data = ed; v.e_mis = emis; v.e_maddr = ema;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called just after a clock edge: every registered response must match the scoreboard head.
    task automatic check_responses();
        resp_t r;
        if (if_valid) begin
            if (sb.size() == 0 || sb[0].is_ld) begin
                chk("unexpected_if_valid", 32'(if_valid), 32'd0);
            end else begin
                r = sb.pop_front();
                chk("if_instr", if_instr, r.data);
                chk("if_misalign", 32'(if_misalign), 32'(r.mis));
            end
        end
        if (ld_valid) begin
            if (sb.size() == 0 || !sb[0].is_ld) begin
                chk("unexpected_ld_valid", 32'(ld_valid), 32'd0);
            end else begin
                r = sb.pop_front();
                chk("ld_rdata", ld_rdata, r.data);
            end
        end
        if (sb.size() != 0) begin
            chk("missing_response", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic apply(vec_t v);
        if_req = v.if_req; if_addr = v.if_addr; ld_req = v.ld_req; ld_we = v.ld_we;
        ld_addr = v.ld_addr; ld_wdata = v.ld_wdata; ld_hold = v.ld_hold;
    endtask

    task automatic check_all_zero(string tag);
        chk({tag, "_if_gnt"}, 32'(if_gnt), 32'd0);
        chk({tag, "_ld_gnt"}, 32'(ld_gnt), 32'd0);
        chk({tag, "_stall_if"}, 32'(stall_if), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_if_valid"}, 32'(if_valid), 32'd0);
        chk({tag, "_if_instr"}, if_instr, 32'd0);
        chk({tag, "_if_misalign"}, 32'(if_misalign), 32'd0);
        chk({tag, "_ld_valid"}, 32'(ld_valid), 32'd0);
        chk({tag, "_ld_rdata"}, ld_rdata, 32'd0);
        chk({tag, "_ld_mode"}, 32'(ld_mode), 32'd0);
    endtask

    vec_t  zero_v;
    resp_t rr;

    initial begin
        for (int i = 0; i < 1024; i++) im[i] = 32'h1000_0000 + i;
        im[0]    = 32'h2008_0005;
        im[1]    = 32'h2109_0003;
        im[2]    = 32'h012a_5020;
        im[4]    = 32'h0000_0444;
        im[1023] = 32'hCAFE_F00D;
        zero_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Fetch-only stream
        vecs.push_back(mk(1, 32'h0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h2008_0005, 0, 10'd0));
        vecs.push_back(mk(1, 32'h4, 0, 0, 0, 0, 0, 1, 0, 0, 32'h2109_0003, 0, 10'd1));
        vecs.push_back(mk(1, 32'h8, 0, 0, 0, 0, 0, 1, 0, 0, 32'h012a_5020, 0, 10'd2));
        // Starvation: fetch wins 4 cycles, loader forced on the 5th, twice
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++)
                vecs.push_back(mk(1, 32'h0, 1, 0, 32'h10, 0, 0, 1, 0, 0, 32'h2008_0005, 0, 10'd0));
            vecs.push_back(mk(1, 32'h0, 1, 0, 32'h10, 0, 0, 0, 1, 0, 32'h0000_0444, 0, 10'd4));
        end
        vecs.push_back(zero_v);
        // Boundaries: last word with misaligned pc; lone loader read granted at once
        vecs.push_back(mk(1, 32'hFFE, 0, 0, 0, 0, 0, 1, 0, 0, 32'hCAFE_F00D, 1, 10'd1023));
        vecs.push_back(mk(0, 0, 1, 0, 32'h8, 0, 0, 0, 1, 0, 32'h012a_5020, 0, 10'd2));
        vecs.push_back(mk(1, 32'h4, 1, 0, 32'hC, 0, 0, 1, 0, 0, 32'h2109_0003, 0, 10'd1));
        // Hold rises with a pending fetch: fetch still wins this cycle, then LOAD write wraps to word 0
        vecs.push_back(mk(1, 32'h0, 1, 1, 32'h1000, 32'hDEAD_BEEF, 1, 1, 0, 0, 32'h2008_0005, 0, 10'd0));
        vecs.push_back(mk(1, 32'h0, 1, 1, 32'h1000, 32'hDEAD_BEEF, 1, 0, 1, 1, 32'h0, 0, 10'd0));
        vecs.push_back(mk(1, 32'h0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h0, 0, 10'd0));
        vecs.push_back(mk(1, 32'h0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 10'd0));
        vecs.push_back(mk(1, 32'h0, 0, 0, 0, 0, 0, 1, 0, 0, 32'hDEAD_BEEF, 0, 10'd0));
        vecs.push_back(mk(0, 0, 1, 0, 32'h1000, 0, 0, 0, 1, 0, 32'hDEAD_BEEF, 0, 10'd0));
        // Write in RUN then read-back by loader and by fetch through an aliased address
        vecs.push_back(mk(0, 0, 1, 1, 32'h20, 32'h1234_5678, 0, 0, 1, 0, 32'h0, 0, 10'd8));
        vecs.push_back(mk(0, 0, 1, 0, 32'h20, 0, 0, 0, 1, 0, 32'h1234_5678, 0, 10'd8));
        vecs.push_back(mk(1, 32'h1020, 0, 0, 0, 0, 0, 1, 0, 0, 32'h1234_5678, 0, 10'd8));

        // Reset state
        #3;
        check_all_zero("reset");
        #4 rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            apply(vecs[i]);
            #2;
            $display("vec %0d: if_req=%0b if_addr=%h ld_req=%0b ld_we=%0b ld_addr=%h hold=%0b -> if_gnt=%0b ld_gnt=%0b mode=%0b",
                     i, vecs[i].if_req, vecs[i].if_addr, vecs[i].ld_req, vecs[i].ld_we,
                     vecs[i].ld_addr, vecs[i].ld_hold, if_gnt, ld_gnt, ld_mode);
            chk($sformatf("v%0d_if_gnt", i), 32'(if_gnt), 32'(vecs[i].e_if_gnt));
            chk($sformatf("v%0d_ld_gnt", i), 32'(ld_gnt), 32'(vecs[i].e_ld_gnt));
            chk($sformatf("v%0d_stall_if", i), 32'(stall_if), 32'(vecs[i].if_req & ~vecs[i].e_if_gnt));
            chk($sformatf("v%0d_ld_mode", i), 32'(ld_mode), 32'(vecs[i].e_mode));
            chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].e_maddr));
            chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].e_ld_gnt & vecs[i].ld_we));
            if (vecs[i].e_ld_gnt && vecs[i].ld_we)
                chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].ld_wdata);
            if (vecs[i].e_if_gnt) begin
                rr.is_ld = 1'b0; rr.data = vecs[i].e_data; rr.mis = vecs[i].e_mis;
                sb.push_back(rr);
            end
            if (vecs[i].e_ld_gnt && !vecs[i].ld_we) begin
                rr.is_ld = 1'b1; rr.data = vecs[i].e_data; rr.mis = 1'b0;
                sb.push_back(rr);
            end
            @(posedge clk); #1;
            check_responses();
        end

        // Reset asserted mid-grant: outputs drop at once and the fetch is never answered
        apply(zero_v);
        if_req = 1'b1; if_addr = 32'h4; ld_hold = 1'b1;
        #2;
        chk("pre_reset_if_gnt", 32'(if_gnt), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge clk); #2;
        apply(zero_v);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_if_valid", 32'(if_valid), 32'd0);
        chk("post_reset_ld_mode", 32'(ld_mode), 32'd0);
        // Back in RUN: a fetch is granted and answered normally
        if_req = 1'b1; if_addr = 32'h4;
        #2;
        chk("post_reset_if_gnt", 32'(if_gnt), 32'd1);
        rr.is_ld = 1'b0; rr.data = 32'h2109_0003; rr.mis = 1'b0;
        sb.push_back(rr);
        @(posedge clk); #1;
        chk("post_reset_resp_valid", 32'(if_valid), 32'd1);
        check_responses();
        apply(zero_v);
        @(posedge clk); #1;
        chk("idle_if_valid", 32'(if_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
